// File: rtl/video_pkg.sv
// Shared types and constants for the video fetch stage: lane geometry,
// FIFO depth, byte-source encoding, and small datapath helpers.
package video_pkg;

    localparam int LANE_W     = 8;
    localparam int GRP_W      = 32;
    localparam int LANES      = GRP_W / LANE_W;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic {
        BSL_LO = 1'b0,
        BSL_HI = 1'b1
    } bsl_e;

    // Pick the byte of a DRAM read word that feeds a lane.
    function automatic logic [LANE_W-1:0] lane_byte(input logic [15:0] rdata, input logic sel_hi);
        logic [LANE_W-1:0] b;
        case (bsl_e'(sel_hi))
            BSL_HI:  b = rdata[15:8];
            BSL_LO:  b = rdata[7:0];
            default: b = rdata[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/video_fetch_if.sv
// DRAM-side and renderer-side handshake of the video fetch stage.
interface video_fetch_if;
    import video_pkg::*;

    logic             video_rq;
    logic             video_strb;
    logic [15:0]      dram_rdata;
    logic             fetch_stb;
    logic [GRP_W-1:0] fetch_data;

    modport master (
        output video_strb, dram_rdata, fetch_stb,
        input  video_rq, fetch_data
    );

    modport slave (
        input  video_strb, dram_rdata, fetch_stb,
        output video_rq, fetch_data
    );

endinterface

// File: rtl/video_fetch_fifo.sv
// Two-entry group FIFO with flush; reports dropped pushes and empty pops
// as single-cycle pulses so the parent can keep the debug counters.
module video_fetch_fifo
    import video_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [GRP_W-1:0] din,
    output logic [GRP_W-1:0] head,
    output logic [1:0]       level,
    output logic             drop,
    output logic             underrun
);

    localparam logic [1:0] FULL_LVL = 2'(DEPTH);

    logic [GRP_W-1:0] mem_r [DEPTH];
    logic             wp_r;
    logic             rp_r;
    logic [1:0]       lvl_r;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic [1:0]       lvl_nxt_s;

    // Accept/refuse decisions; a pop frees a slot for a push in the same cycle.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        drop      = 1'b0;
        underrun  = 1'b0;
        lvl_nxt_s = lvl_r;
        if (flush) begin
            lvl_nxt_s = 2'd0;
        end else begin
            pop_ok_s  = pop && (lvl_r != 2'd0);
            push_ok_s = push && ((lvl_r != FULL_LVL) || pop_ok_s);
            drop      = push && !pop && (lvl_r == FULL_LVL);
            underrun  = pop && (lvl_r == 2'd0);
            case ({push_ok_s, pop_ok_s})
                2'b10:   lvl_nxt_s = lvl_r + 2'd1;
                2'b01:   lvl_nxt_s = lvl_r - 2'd1;
                default: lvl_nxt_s = lvl_r;
            endcase
        end
    end

    // Storage, pointers and level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wp_r  <= 1'b0;
            rp_r  <= 1'b0;
            lvl_r <= 2'd0;
        end else if (flush) begin
            wp_r  <= 1'b0;
            rp_r  <= 1'b0;
            lvl_r <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wp_r] <= din;
                wp_r        <= ~wp_r;
            end
            if (pop_ok_s) begin
                rp_r <= ~rp_r;
            end
            lvl_r <= lvl_nxt_s;
        end
    end

    assign head  = mem_r[rp_r];
    assign level = lvl_r;

endmodule

// File: rtl/video_fetch.sv
// Video fetch stage: assembles 16-bit DRAM words into 32-bit groups,
// queues them for the renderer and paces the video DRAM request.
module video_fetch
    import video_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             line_start_s,
    input  logic [LANES-1:0] fetch_sel,
    input  logic [1:0]       fetch_bsl,
    video_fetch_if.slave     vbus,
    output logic [1:0]       fifo_lvl,
    output logic [7:0]       unf_cnt,
    output logic [7:0]       ovf_cnt
);

    localparam logic [1:0] FULL_LVL = 2'(DEPTH);

    logic [GRP_W-1:0] coll_r;
    logic [GRP_W-1:0] coll_nxt_s;
    logic [LANES-1:0] wm_r;
    logic [LANES-1:0] wm_set_s;
    logic             grp_done_s;
    logic [GRP_W-1:0] head_s;
    logic             drop_s;
    logic             underrun_s;
    logic [GRP_W-1:0] fetch_data_r;
    logic             rq_r;
    logic [7:0]       unf_cnt_r;
    logic [7:0]       ovf_cnt_r;

    // Lane steering: even lanes follow bsl[0], odd lanes bsl[1].
    always_comb begin
        coll_nxt_s = coll_r;
        wm_set_s   = fetch_sel & {LANES{vbus.video_strb}};
        for (int i = 0; i < LANES; i++) begin
            if (wm_set_s[i]) begin
                coll_nxt_s[i*LANE_W +: LANE_W] = lane_byte(vbus.dram_rdata, fetch_bsl[i % 2]);
            end else begin
                coll_nxt_s[i*LANE_W +: LANE_W] = coll_r[i*LANE_W +: LANE_W];
            end
        end
        grp_done_s = ((wm_r | wm_set_s) == {LANES{1'b1}}) && !line_start_s;
    end

    // Collector data and written-mask; line start drops only the mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_r <= '0;
            wm_r   <= '0;
        end else if (line_start_s) begin
            wm_r <= '0;
        end else begin
            coll_r <= coll_nxt_s;
            wm_r   <= grp_done_s ? '0 : (wm_r | wm_set_s);
        end
    end

    video_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (grp_done_s),
        .pop      (vbus.fetch_stb),
        .flush    (line_start_s),
        .din      (coll_nxt_s),
        .head     (head_s),
        .level    (fifo_lvl),
        .drop     (drop_s),
        .underrun (underrun_s)
    );

    // Renderer data, request and debug counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_data_r <= '0;
            rq_r         <= 1'b0;
            unf_cnt_r    <= 8'd0;
            ovf_cnt_r    <= 8'd0;
        end else begin
            rq_r <= (fifo_lvl < FULL_LVL) && !line_start_s;
            if (vbus.fetch_stb && !line_start_s) begin
                fetch_data_r <= underrun_s ? '0 : head_s;
            end
            if (underrun_s) begin
                unf_cnt_r <= sat_inc(unf_cnt_r);
            end
            if (drop_s) begin
                ovf_cnt_r <= sat_inc(ovf_cnt_r);
            end
        end
    end

    assign vbus.fetch_data = fetch_data_r;
    assign vbus.video_rq   = rq_r;
    assign unf_cnt         = unf_cnt_r;
    assign ovf_cnt         = ovf_cnt_r;

endmodule

// File: tb/tb_video_fetch.sv
// Directed bench for video_fetch: a queue-based reference model checked
// every cycle, plus literal expectations from the worked examples.
module tb_video_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       line_start_s;
    logic [3:0] fetch_sel;
    logic [1:0] fetch_bsl;
    logic [1:0] fifo_lvl;
    logic [7:0] unf_cnt;
    logic [7:0] ovf_cnt;

    video_fetch_if vbus ();

    video_fetch #(.DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .line_start_s (line_start_s),
        .fetch_sel    (fetch_sel),
        .fetch_bsl    (fetch_bsl),
        .vbus         (vbus.slave),
        .fifo_lvl     (fifo_lvl),
        .unf_cnt      (unf_cnt),
        .ovf_cnt      (ovf_cnt)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [7:0]  m_coll [4];
    logic [3:0]  m_wm;
    logic [31:0] m_q [$];
    logic [31:0] m_data;
    int          m_unf;
    int          m_ovf;
    logic        m_rq;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_coll[i] = 8'h00;
        m_wm   = 4'h0;
        m_q.delete();
        m_data = 32'h0;
        m_unf  = 0;
        m_ovf  = 0;
        m_rq   = 1'b0;
    endtask

    // One clock of the stage described as a queue of 32-bit groups.
    task automatic model_step();
        int          lvl0;
        logic [3:0]  set;
        logic [31:0] grp;
        lvl0 = m_q.size();
        if (line_start_s) begin
            m_wm = 4'h0;
            m_q.delete();
            m_rq = 1'b0;
        end else begin
            m_rq = (lvl0 < 2);
            set  = vbus.video_strb ? fetch_sel : 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (set[i]) m_coll[i] = fetch_bsl[i % 2] ? vbus.dram_rdata[15:8] : vbus.dram_rdata[7:0];
            end
            m_wm = m_wm | set;
            if (vbus.fetch_stb) begin
                if (lvl0 > 0) begin
                    m_data = m_q.pop_front();
                end else begin
                    m_data = 32'h0;
                    if (m_unf < 255) m_unf++;
                end
            end
            if (m_wm == 4'hF) begin
                m_wm = 4'h0;
                grp  = {m_coll[3], m_coll[2], m_coll[1], m_coll[0]};
                if (lvl0 == 2 && !vbus.fetch_stb) begin
                    if (m_ovf < 255) m_ovf++;
                end else begin
                    m_q.push_back(grp);
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("fetch_data", vbus.fetch_data, m_data);
        chk("fifo_lvl", 32'(fifo_lvl), 32'(m_q.size()));
        chk("unf_cnt", 32'(unf_cnt), 32'(m_unf));
        chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
        chk("video_rq", 32'(vbus.video_rq), 32'(m_rq));
    endtask

    // Called at a falling edge: drive, clock, update model, compare.
    task automatic step(input logic strb, input logic [3:0] sel, input logic [1:0] bsl,
                        input logic [15:0] rd, input logic stb, input logic ls);
        vbus.video_strb = strb;
        fetch_sel       = sel;
        fetch_bsl       = bsl;
        vbus.dram_rdata = rd;
        vbus.fetch_stb  = stb;
        line_start_s    = ls;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 2'b00, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic push_grp(input logic [15:0] rd);
        step(1'b1, 4'hF, 2'b00, rd, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        step(1'b0, 4'h0, 2'b00, 16'h0000, 1'b1, 1'b0);
    endtask

    initial begin
        rst             = 1'b1;
        line_start_s    = 1'b0;
        fetch_sel       = 4'h0;
        fetch_bsl       = 2'b00;
        vbus.video_strb = 1'b0;
        vbus.dram_rdata = 16'h0000;
        vbus.fetch_stb  = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        idle();
        chk("rq_after_reset", 32'(vbus.video_rq), 32'd1);

        // ZX-style halves
        step(1'b1, 4'b0011, 2'b10, 16'hA1B2, 1'b0, 1'b0);
        chk("zx_lvl_half", 32'(fifo_lvl), 32'd0);
        step(1'b1, 4'b1100, 2'b10, 16'hC3D4, 1'b0, 1'b0);
        chk("zx_lvl", 32'(fifo_lvl), 32'd1);
        pop1();
        chk("zx_data", vbus.fetch_data, 32'hC3D4A1B2);

        // text-mode byte duplication
        step(1'b1, 4'b0001, 2'b11, 16'h5A00, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 2'b11, 16'h5A00, 1'b0, 1'b0);
        chk("txt_lvl_2of3", 32'(fifo_lvl), 32'd0);
        step(1'b1, 4'b1100, 2'b11, 16'h5A00, 1'b0, 1'b0);
        chk("txt_lvl", 32'(fifo_lvl), 32'd1);
        pop1();
        chk("txt_data", vbus.fetch_data, 32'h5A5A5A5A);

        // underrun and saturation
        for (int i = 0; i < 3; i++) pop1();
        chk("unf_data", vbus.fetch_data, 32'h0);
        chk("unf_cnt3", 32'(unf_cnt), 32'd3);
        for (int i = 0; i < 300; i++) pop1();
        chk("unf_sat", 32'(unf_cnt), 32'd255);

        // overflow and back-pressure
        push_grp(16'h1111);
        push_grp(16'h2222);
        push_grp(16'h3333);
        chk("ovf_lvl", 32'(fifo_lvl), 32'd2);
        chk("ovf_cnt", 32'(ovf_cnt), 32'd1);
        chk("ovf_rq", 32'(vbus.video_rq), 32'd0);
        pop1();
        chk("ovf_pop1", vbus.fetch_data, 32'h11111111);
        pop1();
        chk("ovf_pop2", vbus.fetch_data, 32'h22222222);
        chk("ovf_empty", 32'(fifo_lvl), 32'd0);

        // simultaneous push and pop while full
        push_grp(16'h4444);
        push_grp(16'h5555);
        step(1'b1, 4'hF, 2'b00, 16'h6666, 1'b1, 1'b0);
        chk("pp_data", vbus.fetch_data, 32'h44444444);
        chk("pp_lvl", 32'(fifo_lvl), 32'd2);
        chk("pp_ovf", 32'(ovf_cnt), 32'd1);
        pop1();
        chk("pp_pop2", vbus.fetch_data, 32'h55555555);
        pop1();
        chk("pp_pop3", vbus.fetch_data, 32'h66666666);

        // flush with partial group and full FIFO
        push_grp(16'hAAAA);
        push_grp(16'hBBBB);
        step(1'b1, 4'b1100, 2'b00, 16'h1234, 1'b0, 1'b0);
        step(1'b0, 4'h0, 2'b00, 16'h0000, 1'b0, 1'b1);
        chk("fl_lvl", 32'(fifo_lvl), 32'd0);
        chk("fl_data_held", vbus.fetch_data, 32'h66666666);
        step(1'b1, 4'b0011, 2'b00, 16'h5678, 1'b0, 1'b0);
        chk("fl_no_stale", 32'(fifo_lvl), 32'd0);
        step(1'b1, 4'hF, 2'b00, 16'h7788, 1'b0, 1'b0);
        chk("fl_push", 32'(fifo_lvl), 32'd1);
        pop1();
        chk("fl_pop", vbus.fetch_data, 32'h88888888);

        // asynchronous reset mid-group
        step(1'b1, 4'b0011, 2'b00, 16'h9999, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_data", vbus.fetch_data, 32'h0);
        chk("rst_lvl", 32'(fifo_lvl), 32'd0);
        chk("rst_unf", 32'(unf_cnt), 32'd0);
        chk("rst_ovf", 32'(ovf_cnt), 32'd0);
        chk("rst_rq", 32'(vbus.video_rq), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        step(1'b1, 4'b1100, 2'b00, 16'h1234, 1'b0, 1'b0);
        chk("rst_mask_clear", 32'(fifo_lvl), 32'd0);
        step(1'b1, 4'b0011, 2'b00, 16'h5678, 1'b0, 1'b0);
        pop1();
        chk("rst_new_grp", vbus.fetch_data, 32'h34347878);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_fetch.md
# video_fetch

Video data fetch stage between the DRAM arbiter and the video renderer. It collects 16-bit DRAM read words into a 32-bit group, steering bytes into lanes under the per-mode `fetch_sel`/`fetch_bsl` controls from the video mode decoder. It queues completed groups in a 2-entry FIFO and hands one group to the renderer on each `fetch_stb`. It also raises the video DRAM request while FIFO space exists and counts underrun/overflow events for debug.

## Interface
Parameters:
- `DEPTH`, 2: FIFO depth in 32-bit groups. Fixed at 2; the level counter is 2 bits.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `line_start_s`  in  1  line-start strobe; flushes the stage.
- `fetch_sel`  in  4  lane write enables; bit i selects lane i = bits [8i+7:8i].
- `fetch_bsl`  in  2  byte source select: bit0 for even lanes, bit1 for odd lanes; 0 = `rdata[7:0]`, 1 = `rdata[15:8]`.
- `video_strb`  in  1  DRAM read data valid this cycle.
- `dram_rdata`  in  16  DRAM read data.
- `fetch_stb`  in  1  renderer pop strobe.
- `video_rq`  out  1  video DRAM request.
- `fetch_data`  out  32  group delivered to the renderer.
- `fifo_lvl`  out  2  FIFO occupancy, 0..2.
- `unf_cnt`  out  8  saturating underrun counter.
- `ovf_cnt`  out  8  saturating overflow counter.

## Operation
- **Collector.** Holds a 32-bit register plus a 4-bit written-mask `wm`.
  - On `video_strb`, every lane i with `fetch_sel[i]=1` loads its selected byte and sets `wm[i]`.
  - Lanes with `fetch_sel[i]=0` keep their value.
- **Group complete.** A group is complete on the cycle where (`wm` | (`fetch_sel` & {4{`video_strb`}})) == 4'hF.
  - On completion, the next-state collector value is pushed, including the current strobe's bytes.
  - `wm` clears to 0.
  - Collector data is kept, not zeroed.
- **FIFO.** 2 entries with write/read pointers and a level.
  - Push on group complete.
  - Pop on `fetch_stb`.
- **Pop.**
  - `fetch_stb` with level>0: `fetch_data` <= head entry; level decrements.
  - `fetch_stb` with level=0 (underrun): `fetch_data` <= 32'h0; `unf_cnt` += 1, saturating at 255.
- **Push when full.** Push with level=2 and no simultaneous pop (overflow): the new group is dropped; `ovf_cnt` += 1, saturating.
- **Simultaneous push and pop.**
  - Level 2: pop the head and accept the new group; level stays 2; no overflow.
  - Level 1: pop the head and push the new group; level stays 1.
  - Level 0: underrun is counted; the new group is written; level becomes 1. No push-through to `fetch_data`.
- **Request.** `video_rq` = (level < 2) & ~line_start_s. Registered; see Timing.
- **Flush.** `line_start_s` flushes the stage; it has priority over push and pop in the same cycle.
  - Pointers, level and `wm` are zeroed.
  - `fetch_data`, counters and collector data are held.

## Timing
- Reset values:
  - `fetch_data` = 0, `fifo_lvl` = 0, `unf_cnt` = 0, `ovf_cnt` = 0, `video_rq` = 0.
  - `wm` = 0 and the collector = 0.
  - Pointers = 0.
- Reset mid-group discards partial data immediately, because reset is asynchronous.
- Latencies:
  - `video_strb` completing a group → entry visible in `fifo_lvl` next cycle.
  - `fetch_stb` → `fetch_data` updated next cycle, held until the next pop.
- `video_rq` is registered.
  - Deassertion reflects a level reaching 2 one cycle late.
  - The arbiter tolerates one extra word in flight; that word completes into the collector, and it is counted as overflow only if the group completes while the FIFO is full.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Shared package `video_pkg`:
  - `LANE_W` = 8 and `GRP_W` = 32.
  - `FIFO_DEPTH` = 2.
  - The `fetch_bsl` encoding: `BSL_LO` = 0 and `BSL_HI` = 1.
- One sub-module, `video_fetch_fifo`: 2-entry 32-bit FIFO with push, pop and flush inputs, level output, and drop/underrun pulse outputs.
- The collector, request logic and counters stay in `video_fetch`.

## Test plan
- **ZX-style pair of halves.**
  - Stimulus: `fetch_sel`=4'b0011 with rdata 16'hA1B2, then 4'b1100 with 16'hC3D4, `fetch_bsl`=2'b10; then `fetch_stb`.
  - Required: `fifo_lvl` reaches 1 after the second strobe; `fetch_data`=32'hC3D4A1B2 one cycle after `fetch_stb`.
- **Text gfx byte duplication.**
  - Stimulus: `fetch_sel`=4'b0001, then 4'b0010, then 4'b1100, with `fetch_bsl`=2'b11 and rdata 16'h5A00 each time.
  - Required: the group is complete only after the third strobe; `fetch_data`=32'h5A5A5A5A.
- **Underrun.**
  - Stimulus: 3× `fetch_stb` on an empty FIFO.
  - Required: `fetch_data`=0 and `unf_cnt`=3.
  - Follow-up: 300 underruns → `unf_cnt`=255.
- **Overflow and back-pressure.**
  - Stimulus: push 3 full groups (32'h11111111, 32'h22222222, 32'h33333333) with no pops.
  - Required: `fifo_lvl`=2, `ovf_cnt`=1, `video_rq`=0; two pops return 32'h11111111 and 32'h22222222.
- **Simultaneous push and pop at level 2.**
  - Required: level stays 2 and `ovf_cnt` unchanged; the pop returns the oldest group.
- **Flush and reset.**
  - Stimulus: `line_start_s` with a partial group and level 2, then one strobe with `fetch_sel`=4'hF.
  - Required: the level goes to 0; the new group is pushed alone and has no stale mask.
  - Then: async `rst` mid-group → all outputs 0 within the same cycle.
